pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Sits beside decode.
//  Keeps shadow copies of EX/MEM/WB destination info and computes stall, flush, bubble and freeze
//  controls from them. Also drives EX operand-forwarding selects and a data-memory wait timeout.
//  Inputs are the per-instruction control bits produced by the decode/control path.
// PARAMETERS
//  REDIRECT_PENALTY  2    cycles flush_id_o stays high per redirect (>=1)
//  MEM_TIMEOUT       64   MEMWAIT cycles before err_o sets (>=1)
// PORTS
//  clk            in   1  clock
//  reset          in   1  synchronous, active-high reset
//  id_valid_i     in   1  ID stage holds a live instruction
//  id_rs1_i       in   5  ID source register 1
//  id_rs2_i       in   5  ID source register 2
//  id_use_rs1_i   in   1  ID instruction reads rs1
//  id_use_rs2_i   in   1  ID instruction reads rs2
//  id_rd_i        in   5  ID destination register
//  id_regwren_i   in   1  ID instruction writes rd
//  id_is_load_i   in   1  ID instruction is a load
//  id_is_mem_i    in   1  ID instruction is a load or a store
//  ex_redirect_i  in   1  EX resolved a taken branch or JAL/JALR
//  dmem_ack_i     in   1  data memory completes the MEM-stage access this cycle
//  stall_if_o     out  1  hold PC/IF register
//  stall_id_o     out  1  hold IF/ID register
//  flush_id_o     out  1  kill the IF/ID contents (insert NOP)
//  bubble_ex_o    out  1  load NOP into ID/EX
//  freeze_o       out  1  hold EX/MEM/WB registers; suppress regfile write
//  fwd_rs1_o      out  2  EX operand A source, fwd_sel_e
//  fwd_rs2_o      out  2  EX operand B source, fwd_sel_e
//  err_o          out  1  sticky memory-timeout flag
// BEHAVIOUR
//  Shadow entry per stage {valid, rd, regwren, is_load, is_mem, rs1, rs2}. EX keeps rs1/rs2; MEM/WB do not.
//  Shadows advance on clk unless freeze_o is high: WB<=MEM, MEM<=EX.
//    EX <= invalid when bubble_ex_o or flush_id_o or !id_valid_i; otherwise EX <= ID inputs.
//  Reset: all shadows invalid, state PS_RUN, counters 0, err_o=0. All outputs are 0 during and after reset.
//  All outputs except err_o are combinational from current state, shadows and inputs. err_o is registered.
//  hz(s,r) = s.valid & s.regwren & s.rd==r & r!=0. x0 never matches.
//  Forwarding, per EX operand r: FWD_MEM if hz(MEM,r) & !MEM.is_load; else FWD_WB if hz(WB,r); else FWD_NONE.
//  freeze_o = MEM.valid & MEM.is_mem & !dmem_ack_i. Overrides everything else.
//    When freeze_o is high: stall_if_o=stall_id_o=1, flush_id_o=bubble_ex_o=0, ex_redirect_i is ignored.
//  Redirect (no freeze): ex_redirect_i sets flush_id_o=1 and bubble_ex_o=0 that same cycle.
//    The flush counter loads REDIRECT_PENALTY-1.
//  Load-use: uses rs1 or rs2 with hz(EX,rs) & EX.is_load & id_valid_i.
//    Result, when there is no freeze and flush_id_o is low: stall_if_o=stall_id_o=bubble_ex_o=1 for exactly 1 cycle.
//    If flush_id_o is high, the load-use stall is suppressed because ID is dead.
//  FSM (fsm state register, values in pipe_state_e):
//    PS_RUN -> PS_FLUSH     on redirect when REDIRECT_PENALTY>1
//    PS_RUN -> PS_MEMWAIT   on freeze
//    PS_FLUSH: flush_id_o=1 while cnt>0, cnt decrements; cnt==0 -> PS_RUN.
//      A redirect while in PS_FLUSH reloads cnt. A freeze in PS_FLUSH holds cnt and goes to PS_MEMWAIT.
//    PS_MEMWAIT: wait counter increments and saturates. At MEM_TIMEOUT it sets err_o; err_o clears only on reset.
//      On dmem_ack_i it returns to PS_FLUSH if cnt>0, otherwise to PS_RUN. The wait counter clears.
//  Reset mid-operation: the next cycle is the clean reset state. No pending flush survives reset.
// STRUCTURE
//  pd_pipe_pkg holds:
//    pipe_state_e {PS_RUN, PS_FLUSH, PS_MEMWAIT}
//    fwd_sel_e {FWD_NONE=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2}
//    shadow_t struct
//  Sub-module fwd_unit is purely combinational. It is instantiated once per EX operand and computes fwd_sel_e.
// TESTING
//  1. ALU chain. addi x5 in EX, then add x6,x5,x5 in ID; one cycle later
//     -> fwd_rs1_o=fwd_rs2_o=FWD_MEM, no stall.
//  2. Load-use. lw x7 in EX, ID uses x7 -> one cycle of stall_if/stall_id/bubble_ex=1.
//     Two cycles later -> fwd=FWD_WB.
//  3. x0. Producer rd=0 with regwren=1 and consumer rs1=0 -> FWD_NONE, no stall.
//  4. Redirect with the default penalty of 2 -> flush_id_o high for exactly 2 cycles.
//     A second redirect in the 2nd cycle -> 2 more flush cycles.
//  5. Memory wait. A store reaches MEM with ack held low for 3 cycles -> freeze_o and stalls high for 3 cycles.
//     Shadows are unchanged. On the ack cycle the pipeline advances.
//  6. Timeout and reset. With MEM_TIMEOUT=4, ack low for 5 cycles -> err_o=1 from the 5th cycle.
//     reset asserted mid-wait -> all outputs 0 the next cycle and err_o=0.

Source files
------------

// File: rtl/pd_pipe_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, forwarding selects,
// per-stage shadow entries and the register-match helper.
package pd_pipe_pkg;

   typedef enum logic [1:0] {
      PS_RUN     = 2'd0,
      PS_FLUSH   = 2'd1,
      PS_MEMWAIT = 2'd2
   } pipe_state_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_MEM  = 2'd1,
      FWD_WB   = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic       valid;
      logic       regwren;
      logic [4:0] rd;
   } dst_t;

   // Source registers are kept only for EX, so they live beside the EX entry.
   typedef struct packed {
      dst_t dst;
      logic is_load;
      logic is_mem;
   } shadow_t;

   function automatic logic hz(input dst_t d, input logic [4:0] r);
      return d.valid & d.regwren & (d.rd == r) & (r != 5'd0);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register; MEM wins over WB,
// but a load still in MEM has no data yet and cannot forward.
module fwd_unit
   import pd_pipe_pkg::*;
(
   input  dst_t       mem_dst,
   input  logic       mem_is_load,
   input  dst_t       wb_dst,
   input  logic [4:0] rs,
   output fwd_sel_e   sel
);

   // Priority select: youngest producer first.
   always_comb begin
      sel = FWD_NONE;
      if (hz(mem_dst, rs) && !mem_is_load) begin
         sel = FWD_MEM;
      end else if (hz(wb_dst, rs)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_NONE;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: tracks EX/MEM/WB destination shadows and derives stall, flush,
// bubble, freeze, forwarding selects and a sticky data-memory timeout flag.
module pipe_hazard_ctrl
   import pd_pipe_pkg::*;
#(
   parameter int unsigned REDIRECT_PENALTY = 2,
   parameter int unsigned MEM_TIMEOUT      = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs1_i,
   input  logic       id_use_rs2_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_regwren_i,
   input  logic       id_is_load_i,
   input  logic       id_is_mem_i,
   input  logic       ex_redirect_i,
   input  logic       dmem_ack_i,
   output logic       stall_if_o,
   output logic       stall_id_o,
   output logic       flush_id_o,
   output logic       bubble_ex_o,
   output logic       freeze_o,
   output fwd_sel_e   fwd_rs1_o,
   output fwd_sel_e   fwd_rs2_o,
   output logic       err_o
);

   localparam int unsigned CW = (REDIRECT_PENALTY > 1) ? $clog2(REDIRECT_PENALTY) : 1;
   localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(REDIRECT_PENALTY - 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);
   localparam pipe_state_e   REDIR_STATE = (REDIRECT_PENALTY > 1) ? PS_FLUSH : PS_RUN;

   pipe_state_e   state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [WW-1:0] wcnt_r, wcnt_s;
   logic          err_r, err_s;
   shadow_t       ex_r, mem_r;
   logic [4:0]    ex_rs1_r, ex_rs2_r;
   dst_t          wb_r;
   shadow_t       id_sh_s;
   logic          freeze_s, load_use_s, flush_s, bubble_s, ex_kill_s;
   fwd_sel_e      fwd1_s, fwd2_s;

   assign id_sh_s = {1'b1, id_regwren_i, id_rd_i, id_is_load_i, id_is_mem_i};

   // Hazard detection, flush sequencing and memory-wait accounting.
   always_comb begin
      freeze_s   = mem_r.dst.valid & mem_r.is_mem & ~dmem_ack_i;
      load_use_s = id_valid_i & ex_r.dst.valid & ex_r.is_load &
                   ((id_use_rs1_i & hz(ex_r.dst, id_rs1_i)) |
                    (id_use_rs2_i & hz(ex_r.dst, id_rs2_i)));
      state_s = state_r;
      cnt_s   = cnt_r;
      flush_s = 1'b0;
      if (freeze_s) begin
         state_s = PS_MEMWAIT;
         cnt_s   = cnt_r;
      end else if (ex_redirect_i) begin
         flush_s = 1'b1;
         cnt_s   = CNT_LOAD;
         state_s = REDIR_STATE;
      end else begin
         case (state_r)
            PS_RUN: begin
               state_s = PS_RUN;
               cnt_s   = cnt_r;
            end
            PS_FLUSH: begin
               if (cnt_r != '0) begin
                  flush_s = 1'b1;
                  cnt_s   = cnt_r - CW'(1);
                  state_s = (cnt_r == CW'(1)) ? PS_RUN : PS_FLUSH;
               end else begin
                  cnt_s   = '0;
                  state_s = PS_RUN;
               end
            end
            PS_MEMWAIT: begin
               state_s = (cnt_r != '0) ? PS_FLUSH : PS_RUN;
               cnt_s   = cnt_r;
            end
            default: begin
               state_s = PS_RUN;
               cnt_s   = '0;
            end
         endcase
      end
      bubble_s  = load_use_s & ~freeze_s & ~flush_s;
      ex_kill_s = bubble_s | flush_s | ~id_valid_i;
      if (freeze_s) begin
         wcnt_s = (wcnt_r == WAIT_MAX) ? wcnt_r : wcnt_r + WW'(1);
      end else begin
         wcnt_s = '0;
      end
      err_s = err_r | (wcnt_s == WAIT_MAX);
   end

   fwd_unit u_fwd_rs1 (
      .mem_dst     (mem_r.dst),
      .mem_is_load (mem_r.is_load),
      .wb_dst      (wb_r),
      .rs          (ex_rs1_r),
      .sel         (fwd1_s)
   );

   fwd_unit u_fwd_rs2 (
      .mem_dst     (mem_r.dst),
      .mem_is_load (mem_r.is_load),
      .wb_dst      (wb_r),
      .rs          (ex_rs2_r),
      .sel         (fwd2_s)
   );

   // Outputs are forced quiet while reset is held.
   always_comb begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      flush_id_o  = 1'b0;
      bubble_ex_o = 1'b0;
      freeze_o    = 1'b0;
      fwd_rs1_o   = FWD_NONE;
      fwd_rs2_o   = FWD_NONE;
      if (!reset) begin
         stall_if_o  = freeze_s | bubble_s;
         stall_id_o  = freeze_s | bubble_s;
         flush_id_o  = flush_s;
         bubble_ex_o = bubble_s;
         freeze_o    = freeze_s;
         fwd_rs1_o   = fwd1_s;
         fwd_rs2_o   = fwd2_s;
      end else begin
         fwd_rs1_o   = FWD_NONE;
         fwd_rs2_o   = FWD_NONE;
      end
   end

   assign err_o = err_r;

   // State, counters and stage shadows; a freeze holds every shadow in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= PS_RUN;
         cnt_r    <= '0;
         wcnt_r   <= '0;
         err_r    <= 1'b0;
         ex_r     <= '0;
         ex_rs1_r <= 5'd0;
         ex_rs2_r <= 5'd0;
         mem_r    <= '0;
         wb_r     <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         wcnt_r  <= wcnt_s;
         err_r   <= err_s;
         if (!freeze_s) begin
            wb_r  <= mem_r.dst;
            mem_r <= ex_r;
            if (ex_kill_s) begin
               ex_r     <= '0;
               ex_rs1_r <= 5'd0;
               ex_rs2_r <= 5'd0;
            end else begin
               ex_r     <= id_sh_s;
               ex_rs1_r <= id_rs1_i;
               ex_rs2_r <= id_rs2_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver queues hand-computed output vectors
// per cycle and a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

   localparam logic [1:0] FN = 2'd0;
   localparam logic [1:0] FM = 2'd1;
   localparam logic [1:0] FW = 2'd2;
   localparam logic [9:0] ALL = 10'h3FF;
   localparam logic [9:0] NO_ERR = 10'h3FE;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_regwren, id_is_load, id_is_mem;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_redirect, dmem_ack;
   logic       stall_if, stall_id, flush_id, bubble_ex, freeze, err;
   logic [1:0] fwd_rs1, fwd_rs2;
   logic [9:0] act;

   typedef struct {
      logic [9:0] val;
      logic [9:0] mask;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REDIRECT_PENALTY(2), .MEM_TIMEOUT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_use_rs1_i  (id_use_rs1),
      .id_use_rs2_i  (id_use_rs2),
      .id_rd_i       (id_rd),
      .id_regwren_i  (id_regwren),
      .id_is_load_i  (id_is_load),
      .id_is_mem_i   (id_is_mem),
      .ex_redirect_i (ex_redirect),
      .dmem_ack_i    (dmem_ack),
      .stall_if_o    (stall_if),
      .stall_id_o    (stall_id),
      .flush_id_o    (flush_id),
      .bubble_ex_o   (bubble_ex),
      .freeze_o      (freeze),
      .fwd_rs1_o     (fwd_rs1),
      .fwd_rs2_o     (fwd_rs2),
      .err_o         (err)
   );

   assign act = {stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_rs1, fwd_rs2, err};

   // Monitor: one expected vector per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if ((act & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (care %b)", mon_e.name, act, mon_e.val, mon_e.mask);
         end
      end
   end

   function automatic logic [9:0] o(input logic si, input logic sd, input logic fl, input logic bb,
                                    input logic fz, input logic [1:0] f1, input logic [1:0] f2,
                                    input logic er);
      return {si, sd, fl, bb, fz, f1, f2, er};
   endfunction

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic mem);
      id_valid   = v;
      id_rs1     = rs1;
      id_rs2     = rs2;
      id_use_rs1 = u1;
      id_use_rs2 = u2;
      id_rd      = rd;
      id_regwren = wr;
      id_is_load = ld;
      id_is_mem  = mem;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cyc(input logic [9:0] val, input string nm, input logic [9:0] mask = ALL);
      exp_t e;
      e.val  = val;
      e.mask = mask;
      e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   logic [9:0] z, fl, fz;

   initial begin
      z  = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FN, FN, 1'b0);
      fl = o(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FN, FN, 1'b0);
      fz = o(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FN, FN, 1'b0);
      reset = 1'b1;
      ex_redirect = 1'b0;
      dmem_ack = 1'b1;
      idle();
      @(posedge clk);
      #1;

      // Reset: outputs quiet even with hazardous-looking inputs
      set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
      ex_redirect = 1'b1;
      cyc(z, "reset_outputs");
      cyc(z, "reset_outputs2");
      reset = 1'b0;
      ex_redirect = 1'b0;
      idle();
      cyc(z, "post_reset");

      // ALU chain: addi x5,x1 then add x6,x5,x5
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      cyc(z, "alu_prod");
      set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      cyc(z, "alu_cons_no_stall");
      idle();
      cyc(o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FM, FM, 1'b0), "alu_fwd_mem");
      cyc(z, "alu_drain1");
      cyc(z, "alu_drain2");
      cyc(z, "alu_drain3");

      // Load-use: lw x7 then add x8,x7,x3
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
      cyc(z, "lw_issue");
      set_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      cyc(o(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, FN, FN, 1'b0), "load_use_stall");
      cyc(z, "load_use_release");
      idle();
      cyc(o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FW, FN, 1'b0), "load_fwd_wb");
      cyc(z, "lu_drain1");
      cyc(z, "lu_drain2");

      // x0: load rd=0, ALU rd=0 reading x0, consumer reading x0 twice
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
      cyc(z, "x0_load_prod");
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc(z, "x0_no_load_use");
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      cyc(z, "x0_cons_issue");
      idle();
      cyc(z, "x0_no_fwd");
      cyc(z, "x0_drain1");
      cyc(z, "x0_drain2");

      // Redirect suppresses a coincident load-use stall; penalty 2
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
      cyc(z, "redir_pre_lw");
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      ex_redirect = 1'b1;
      cyc(fl, "redir_kills_load_use");
      ex_redirect = 1'b0;
      idle();
      cyc(fl, "redir_flush2");
      cyc(z, "redir_done");

      // Back-to-back redirect reloads the penalty
      ex_redirect = 1'b1;
      cyc(fl, "rr_first");
      cyc(fl, "rr_second");
      ex_redirect = 1'b0;
      cyc(fl, "rr_tail");
      cyc(z, "rr_done");

      // Memory wait: sw in MEM, ack low 3 cycles, addi x11 held in EX
      set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc(z, "st_issue");
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
      cyc(z, "addi_issue");
      set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
      dmem_ack = 1'b0;
      cyc(fz, "memwait1");
      ex_redirect = 1'b1;
      cyc(fz, "memwait2_redir_ignored");
      ex_redirect = 1'b0;
      cyc(fz, "memwait3");
      dmem_ack = 1'b1;
      cyc(z, "mem_ack_advance");
      idle();
      cyc(o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FM, FN, 1'b0), "post_wait_fwd_mem");
      cyc(z, "mw_drain1");
      cyc(z, "mw_drain2");

      // Timeout: lw in MEM, ack low; err from the 5th wait cycle, then reset mid-wait
      set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 1'b1);
      cyc(z, "to_lw_issue");
      idle();
      cyc(z, "to_lw_ex");
      dmem_ack = 1'b0;
      cyc(fz, "to_wait1");
      cyc(fz, "to_wait2");
      cyc(fz, "to_wait3");
      cyc(fz, "to_wait4");
      cyc(fz | 10'd1, "to_wait5_err");
      reset = 1'b1;
      cyc(z, "reset_mid_wait", NO_ERR);
      reset = 1'b0;
      cyc(z, "after_reset_clean");
      dmem_ack = 1'b1;

      // Pending flush does not survive reset
      ex_redirect = 1'b1;
      cyc(fl, "pre_reset_redir");
      ex_redirect = 1'b0;
      reset = 1'b1;
      cyc(z, "reset_in_flush");
      reset = 1'b0;
      cyc(z, "no_flush_after_reset");

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
